// File: rtl/rv_pipeline_ctrl.sv
// Pipeline control for the RV32IM core: stage stall/kill, GPR write scoreboard, mispredict flush.
// Optional perf counters are built when RV_PIPELINE_CTRL_PERF_EN is defined.
module rv_pipeline_ctrl #(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned GPR_ADDR_W   = 5
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  f_valid_i,
    input  logic [GPR_ADDR_W-1:0] f_cu_rs1_addr_i,
    input  logic                  f_cu_rs1_req_i,
    input  logic [GPR_ADDR_W-1:0] f_cu_rs2_addr_i,
    input  logic                  f_cu_rs2_req_i,
    input  logic [GPR_ADDR_W-1:0] f_cu_rd_addr_i,
    input  logic                  f_cu_rd_we_i,
    input  logic                  d_stall_req_i,
    input  logic                  e_stall_req_i,
    input  logic                  m_stall_req_i,
    input  logic                  e_mispredict_i,
    input  logic                  m_gpr_wr_en_i,
    input  logic [GPR_ADDR_W-1:0] m_gpr_wr_addr_i,
    output logic                  cu_stall_f_o,
    output logic                  cu_stall_d_o,
    output logic                  cu_stall_e_o,
    output logic                  cu_stall_m_o,
    output logic                  cu_kill_f_o,
    output logic                  cu_kill_d_o,
    output logic                  cu_kill_e_o,
    output logic                  cu_redirect_o
`ifdef RV_PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]           hazard_stall_cnt_o,
    output logic [31:0]           flush_cnt_o,
    output logic [31:0]           mdu_stall_cnt_o
`endif
);

    localparam int unsigned       NumRegs   = 2 ** GPR_ADDR_W;
    localparam int unsigned       FlushW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FlushW-1:0] FlushInit = FlushW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CntMax    = {CNT_W{1'b1}};

    typedef enum logic {StRun = 1'b0, StFlush = 1'b1} state_e;

    state_e                        r_state, w_state_nxt;
    logic [FlushW-1:0]             r_flush_cnt, w_flush_cnt_nxt;
    logic [NumRegs-1:0][CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic                          r_trk_valid, w_trk_valid_nxt;
    logic [GPR_ADDR_W-1:0]         r_trk_rd, w_trk_rd_nxt;
    logic                          r_trk_we, w_trk_we_nxt;

    logic w_run;
    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_rd_full;
    logic w_hazard;
    logic w_mispredict;
    logic w_issue;
    logic w_trk_kill;
    logic w_underflow;

    assign w_run = (r_state == StRun);

    // Hazards use registered counts only: a same-cycle retire is not visible to the decode read.
    assign w_rs1_busy = f_cu_rs1_req_i & (f_cu_rs1_addr_i != '0) &
                        (r_cnt[f_cu_rs1_addr_i] != '0);
    assign w_rs2_busy = f_cu_rs2_req_i & (f_cu_rs2_addr_i != '0) &
                        (r_cnt[f_cu_rs2_addr_i] != '0);
    assign w_rd_full  = f_cu_rd_we_i & (f_cu_rd_addr_i != '0) &
                        (r_cnt[f_cu_rd_addr_i] == CntMax);
    assign w_hazard   = f_valid_i & (w_rs1_busy | w_rs2_busy | w_rd_full);

    assign w_mispredict = w_run & e_mispredict_i & ~m_stall_req_i;
    assign w_issue      = w_run & f_valid_i & ~cu_stall_f_o & ~cu_stall_d_o & ~cu_kill_d_o;
    assign w_trk_kill   = w_mispredict & r_trk_valid & r_trk_we & (r_trk_rd != '0);

    always_comb begin
        cu_stall_f_o  = 1'b0;
        cu_stall_d_o  = 1'b0;
        cu_stall_e_o  = 1'b0;
        cu_stall_m_o  = 1'b0;
        cu_kill_f_o   = 1'b0;
        cu_kill_d_o   = 1'b0;
        cu_kill_e_o   = 1'b0;
        cu_redirect_o = 1'b0;

        if (m_stall_req_i) begin
            cu_stall_f_o = 1'b1;
            cu_stall_d_o = 1'b1;
            cu_stall_e_o = 1'b1;
            cu_stall_m_o = 1'b1;
        end else if (e_stall_req_i) begin
            cu_stall_f_o = 1'b1;
            cu_stall_d_o = 1'b1;
            cu_stall_e_o = 1'b1;
        end else if (d_stall_req_i || w_hazard) begin
            // Decode keeps advancing so it latches a bubble behind the held fetch.
            cu_stall_f_o = 1'b1;
        end

        if (!w_run) begin
            cu_kill_f_o  = 1'b1;
            cu_stall_d_o = 1'b0;
        end

        if (w_mispredict) begin
            cu_kill_f_o   = 1'b1;
            cu_kill_d_o   = 1'b1;
            cu_redirect_o = 1'b1;
            cu_kill_e_o   = d_stall_req_i;
        end
    end

    // Flush lasts FLUSH_CYCLES-1 cycles after the redirect cycle, but never less than one.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            StRun: begin
                if (w_mispredict) begin
                    w_state_nxt     = StFlush;
                    w_flush_cnt_nxt = FlushInit;
                end
            end
            StFlush: begin
                if (r_flush_cnt <= FlushW'(1)) begin
                    w_state_nxt     = StRun;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FlushW'(1);
                end
            end
            default: begin
                w_state_nxt     = StRun;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_trk_valid_nxt = r_trk_valid;
        w_trk_rd_nxt    = r_trk_rd;
        w_trk_we_nxt    = r_trk_we;
        if (w_mispredict) begin
            w_trk_valid_nxt = 1'b0;
        end else if (w_issue) begin
            w_trk_valid_nxt = 1'b1;
            w_trk_rd_nxt    = f_cu_rd_addr_i;
            w_trk_we_nxt    = f_cu_rd_we_i;
        end else if (!cu_stall_d_o) begin
            w_trk_valid_nxt = 1'b0;
        end
    end

    always_comb begin : cnt_nxt
        int v;
        w_cnt_nxt   = r_cnt;
        w_underflow = 1'b0;
        v           = 0;
        // x0 is never tracked, so its counter stays at reset value.
        for (int unsigned i = 1; i < NumRegs; i++) begin
            v = int'(r_cnt[i]);
            if (w_issue && f_cu_rd_we_i && (f_cu_rd_addr_i == GPR_ADDR_W'(i))) begin
                v = v + 1;
            end
            if (m_gpr_wr_en_i && (m_gpr_wr_addr_i == GPR_ADDR_W'(i))) begin
                v = v - 1;
            end
            if (w_trk_kill && (r_trk_rd == GPR_ADDR_W'(i))) begin
                v = v - 1;
            end
            if (v < 0) begin
                w_underflow  = 1'b1;
                w_cnt_nxt[i] = '0;
            end else begin
                w_cnt_nxt[i] = CNT_W'(v);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state     <= StRun;
            r_flush_cnt <= '0;
            r_cnt       <= '0;
            r_trk_valid <= 1'b0;
            r_trk_rd    <= '0;
            r_trk_we    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_trk_valid <= w_trk_valid_nxt;
            r_trk_rd    <= w_trk_rd_nxt;
            r_trk_we    <= w_trk_we_nxt;
            assert (!w_underflow);
        end
    end

`ifdef RV_PIPELINE_CTRL_PERF_EN
    logic [31:0] r_perf_hazard;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_mdu;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_perf_hazard <= '0;
            r_perf_flush  <= '0;
            r_perf_mdu    <= '0;
        end else begin
            if (w_hazard && !d_stall_req_i && !e_stall_req_i && !m_stall_req_i) begin
                r_perf_hazard <= r_perf_hazard + 32'd1;
            end
            if (w_mispredict) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (e_stall_req_i && !m_stall_req_i) begin
                r_perf_mdu <= r_perf_mdu + 32'd1;
            end
        end
    end

    assign hazard_stall_cnt_o = r_perf_hazard;
    assign flush_cnt_o        = r_perf_flush;
    assign mdu_stall_cnt_o    = r_perf_mdu;
`endif

endmodule

// File: tb/tb_rv_pipeline_ctrl.sv
// Bench for rv_pipeline_ctrl: directed scenarios plus random traffic against an integer-level model.
module tb_rv_pipeline_ctrl;

    localparam int CNT_W        = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int GPR_ADDR_W   = 5;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;
    localparam int FLUSH_LEN    = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 1;

    logic                  clk_i = 1'b0;
    logic                  arstn_i;
    logic                  f_valid_i;
    logic [GPR_ADDR_W-1:0] f_cu_rs1_addr_i;
    logic                  f_cu_rs1_req_i;
    logic [GPR_ADDR_W-1:0] f_cu_rs2_addr_i;
    logic                  f_cu_rs2_req_i;
    logic [GPR_ADDR_W-1:0] f_cu_rd_addr_i;
    logic                  f_cu_rd_we_i;
    logic                  d_stall_req_i;
    logic                  e_stall_req_i;
    logic                  m_stall_req_i;
    logic                  e_mispredict_i;
    logic                  m_gpr_wr_en_i;
    logic [GPR_ADDR_W-1:0] m_gpr_wr_addr_i;
    logic                  cu_stall_f_o;
    logic                  cu_stall_d_o;
    logic                  cu_stall_e_o;
    logic                  cu_stall_m_o;
    logic                  cu_kill_f_o;
    logic                  cu_kill_d_o;
    logic                  cu_kill_e_o;
    logic                  cu_redirect_o;
    logic [7:0]            outs;

    assign outs = {cu_stall_f_o, cu_stall_d_o, cu_stall_e_o, cu_stall_m_o,
                   cu_kill_f_o, cu_kill_d_o, cu_kill_e_o, cu_redirect_o};

    always #5 clk_i = ~clk_i;

    rv_pipeline_ctrl #(
        .CNT_W        (CNT_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .GPR_ADDR_W   (GPR_ADDR_W)
    ) dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .f_valid_i       (f_valid_i),
        .f_cu_rs1_addr_i (f_cu_rs1_addr_i),
        .f_cu_rs1_req_i  (f_cu_rs1_req_i),
        .f_cu_rs2_addr_i (f_cu_rs2_addr_i),
        .f_cu_rs2_req_i  (f_cu_rs2_req_i),
        .f_cu_rd_addr_i  (f_cu_rd_addr_i),
        .f_cu_rd_we_i    (f_cu_rd_we_i),
        .d_stall_req_i   (d_stall_req_i),
        .e_stall_req_i   (e_stall_req_i),
        .m_stall_req_i   (m_stall_req_i),
        .e_mispredict_i  (e_mispredict_i),
        .m_gpr_wr_en_i   (m_gpr_wr_en_i),
        .m_gpr_wr_addr_i (m_gpr_wr_addr_i),
        .cu_stall_f_o    (cu_stall_f_o),
        .cu_stall_d_o    (cu_stall_d_o),
        .cu_stall_e_o    (cu_stall_e_o),
        .cu_stall_m_o    (cu_stall_m_o),
        .cu_kill_f_o     (cu_kill_f_o),
        .cu_kill_d_o     (cu_kill_d_o),
        .cu_kill_e_o     (cu_kill_e_o),
        .cu_redirect_o   (cu_redirect_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: pending-write count per GPR, the instruction sitting in decode,
    // and the number of flush cycles still to come.
    int m_cnt [32];
    bit m_trk_v;
    int m_trk_rd;
    bit m_trk_we;
    int m_flush_left;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_trk_v      = 1'b0;
        m_trk_rd     = 0;
        m_trk_we     = 1'b0;
        m_flush_left = 0;
    endtask

    function automatic logic [63:0] model_cnt_vec();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i*2 +: 2] = 2'(m_cnt[i]);
        return v;
    endfunction

    function automatic int trk_pending(input int r);
        return (m_trk_v && m_trk_we && m_trk_rd != 0 && m_trk_rd == r) ? 1 : 0;
    endfunction

    function automatic logic [7:0] model_out(output bit mp_acc, output bit issue);
        bit run, haz, sf, sd, se, sm;
        run = (m_flush_left == 0);
        haz = f_valid_i &&
              ((f_cu_rs1_req_i && f_cu_rs1_addr_i != 0 && m_cnt[f_cu_rs1_addr_i] != 0) ||
               (f_cu_rs2_req_i && f_cu_rs2_addr_i != 0 && m_cnt[f_cu_rs2_addr_i] != 0) ||
               (f_cu_rd_we_i && f_cu_rd_addr_i != 0 && m_cnt[f_cu_rd_addr_i] == CNT_MAX));
        mp_acc = e_mispredict_i && run && !m_stall_req_i;
        sm     = m_stall_req_i;
        se     = m_stall_req_i || e_stall_req_i;
        sd     = run && se;
        sf     = se || d_stall_req_i || haz;
        issue  = f_valid_i && !sf && !sd && !mp_acc && run;
        return {sf, sd, se, sm, mp_acc || !run, mp_acc, mp_acc && d_stall_req_i, mp_acc};
    endfunction

    task automatic model_update(input bit mp_acc, input bit issue, input bit sd);
        int kill_rd;
        kill_rd = (mp_acc && m_trk_v && m_trk_we && m_trk_rd != 0) ? m_trk_rd : 0;
        if (issue && f_cu_rd_we_i && f_cu_rd_addr_i != 0) m_cnt[f_cu_rd_addr_i]++;
        if (m_gpr_wr_en_i && m_gpr_wr_addr_i != 0 && m_cnt[m_gpr_wr_addr_i] > 0)
            m_cnt[m_gpr_wr_addr_i]--;
        if (kill_rd != 0 && m_cnt[kill_rd] > 0) m_cnt[kill_rd]--;
        if (mp_acc) begin
            m_trk_v = 1'b0;
        end else if (issue) begin
            m_trk_v  = 1'b1;
            m_trk_rd = int'(f_cu_rd_addr_i);
            m_trk_we = f_cu_rd_we_i;
        end else if (!sd) begin
            m_trk_v = 1'b0;
        end
        if (mp_acc) m_flush_left = FLUSH_LEN;
        else if (m_flush_left > 0) m_flush_left--;
    endtask

    // Inputs are driven 1 after the edge; outputs sampled 4 after the edge.
    task automatic step(input bit settled);
        logic [7:0] exp_o;
        bit         mp_acc;
        bit         issue;
        if (!settled) #3;
        exp_o = model_out(mp_acc, issue);
        check_eq("outs", {56'd0, outs}, {56'd0, exp_o});
        check_eq("cnt", dut.r_cnt, model_cnt_vec());
        @(posedge clk_i);
        model_update(mp_acc, issue, exp_o[6]);
        #1;
    endtask

    task automatic idle();
        f_valid_i       = 1'b0;
        f_cu_rs1_addr_i = '0;
        f_cu_rs1_req_i  = 1'b0;
        f_cu_rs2_addr_i = '0;
        f_cu_rs2_req_i  = 1'b0;
        f_cu_rd_addr_i  = '0;
        f_cu_rd_we_i    = 1'b0;
        d_stall_req_i   = 1'b0;
        e_stall_req_i   = 1'b0;
        m_stall_req_i   = 1'b0;
        e_mispredict_i  = 1'b0;
        m_gpr_wr_en_i   = 1'b0;
        m_gpr_wr_addr_i = '0;
    endtask

    task automatic apply_reset();
        arstn_i = 1'b0;
        idle();
        model_reset();
        #3;
        check_eq("rst_outs", {56'd0, outs}, 64'd0);
        check_eq("rst_cnt", dut.r_cnt, 64'd0);
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
    endtask

    task automatic drive_write(input int rd);
        idle();
        f_valid_i      = 1'b1;
        f_cu_rd_addr_i = 5'(rd);
        f_cu_rd_we_i   = 1'b1;
    endtask

    task automatic drive_read(input int rs1);
        idle();
        f_valid_i       = 1'b1;
        f_cu_rs1_addr_i = 5'(rs1);
        f_cu_rs1_req_i  = 1'b1;
    endtask

    initial begin
        int q[$];
        apply_reset();

        // RAW on x5
        drive_write(5);
        #3 check_eq("raw_issue", 64'(cu_stall_f_o), 64'd0);
        step(1);
        drive_read(5);
        #3 check_eq("raw_stall_f", 64'(cu_stall_f_o), 64'd1);
        check_eq("raw_stall_d", 64'(cu_stall_d_o), 64'd0);
        step(1);
        step(0);
        m_gpr_wr_en_i   = 1'b1;
        m_gpr_wr_addr_i = 5'd5;
        #3 check_eq("raw_stall_on_retire", 64'(cu_stall_f_o), 64'd1);
        step(1);
        m_gpr_wr_en_i = 1'b0;
        #3 check_eq("raw_release", 64'(cu_stall_f_o), 64'd0);
        step(1);

        // x0 is never tracked
        apply_reset();
        drive_write(0);
        step(0);
        drive_read(0);
        #3 check_eq("x0_nostall", 64'(cu_stall_f_o), 64'd0);
        step(1);
        check_eq("x0_cnt", dut.r_cnt, 64'd0);

        // Saturation on x7
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_write(7);
            #3 check_eq("sat_issue", 64'(cu_stall_f_o), 64'd0);
            step(1);
        end
        drive_write(7);
        #3 check_eq("sat_full", 64'(cu_stall_f_o), 64'd1);
        step(1);
        m_gpr_wr_en_i   = 1'b1;
        m_gpr_wr_addr_i = 5'd7;
        #3 check_eq("sat_full_retire", 64'(cu_stall_f_o), 64'd1);
        step(1);
        m_gpr_wr_en_i = 1'b0;
        #3 check_eq("sat_reissue", 64'(cu_stall_f_o), 64'd0);
        step(1);
        idle();
        #3 check_eq("sat_cnt7", 64'(dut.r_cnt[7]), 64'd3);
        step(1);

        // Mispredict with a write to x3 sitting in decode
        apply_reset();
        drive_write(3);
        step(0);
        idle();
        e_mispredict_i = 1'b1;
        #3 check_eq("mp_kf_kd_redir", 64'({cu_kill_f_o, cu_kill_d_o, cu_redirect_o}), 64'd7);
        check_eq("mp_kill_e", 64'(cu_kill_e_o), 64'd0);
        step(1);
        idle();
        #3 check_eq("mp_flush_kf", 64'(cu_kill_f_o), 64'd1);
        check_eq("mp_flush_redir", 64'(cu_redirect_o), 64'd0);
        step(1);
        #3 check_eq("mp_kf_done", 64'(cu_kill_f_o), 64'd0);
        check_eq("mp_cnt3", 64'(dut.r_cnt[3]), 64'd0);
        step(1);

        // Stall priority
        apply_reset();
        drive_write(4);
        step(0);
        drive_read(4);
        m_stall_req_i = 1'b1;
        e_stall_req_i = 1'b1;
        #3 check_eq("prio_all", 64'({cu_stall_f_o, cu_stall_d_o, cu_stall_e_o, cu_stall_m_o}),
                    64'hf);
        step(1);
        check_eq("prio_cnt", dut.r_cnt, 64'h100);
        m_stall_req_i = 1'b0;
        #3 check_eq("prio_e", 64'({cu_stall_f_o, cu_stall_d_o, cu_stall_e_o, cu_stall_m_o}),
                    64'he);
        step(1);

        // Mispredict plus retire on x9, then reset during FLUSH
        apply_reset();
        drive_write(9);
        step(0);
        step(0);
        idle();
        e_mispredict_i  = 1'b1;
        m_gpr_wr_en_i   = 1'b1;
        m_gpr_wr_addr_i = 5'd9;
        step(0);
        check_eq("mp_ret_cnt9", 64'(dut.r_cnt[9]), 64'd0);
        idle();
        #3 check_eq("flush_before_rst", 64'(cu_kill_f_o), 64'd1);
        apply_reset();
        idle();
        #3 check_eq("rst_run_kf", 64'(cu_kill_f_o), 64'd0);
        step(1);

        // Random traffic
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            f_valid_i       = ($urandom_range(0, 9) < 7);
            f_cu_rs1_addr_i = 5'($urandom_range(0, 7));
            f_cu_rs1_req_i  = 1'($urandom_range(0, 1));
            f_cu_rs2_addr_i = 5'($urandom_range(0, 7));
            f_cu_rs2_req_i  = 1'($urandom_range(0, 1));
            f_cu_rd_addr_i  = 5'($urandom_range(0, 7));
            f_cu_rd_we_i    = 1'($urandom_range(0, 1));
            d_stall_req_i   = ($urandom_range(0, 99) < 15);
            e_stall_req_i   = ($urandom_range(0, 99) < 10);
            m_stall_req_i   = ($urandom_range(0, 99) < 8);
            e_mispredict_i  = ($urandom_range(0, 99) < 5);
            // Only retire writes that are actually in flight beyond decode.
            q.delete();
            for (int r = 1; r < 8; r++) begin
                if (m_cnt[r] - trk_pending(r) > 0) q.push_back(r);
            end
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                m_gpr_wr_en_i   = 1'b1;
                m_gpr_wr_addr_i = 5'(q[$urandom_range(0, q.size() - 1)]);
            end
            step(0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_pipeline_ctrl.md
Name: rv_pipeline_ctrl

Overview:
Pipeline control unit for the RV32IM core. It sequences fetch, decode, execute and memory stages:
- generates per-stage stall and kill signals;
- tracks in-flight GPR writes in a per-register scoreboard to resolve RAW and WAW hazards, since the decode-stage register file has no bypass;
- sequences the flush after a branch/jump misprediction.

Parameters:
CNT_W, 2, width of per-register in-flight counter; max in-flight writes per register = 2**CNT_W-1
FLUSH_CYCLES, 2, cycles cu_kill_f_o stays asserted after a misprediction (>=1)
GPR_ADDR_W, 5, register address width

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
f_valid_i  in  1  fetch presents a valid instruction to decode
f_cu_rs1_addr_i  in  GPR_ADDR_W  rs1 of instruction in decode input
f_cu_rs1_req_i  in  1  rs1 is read
f_cu_rs2_addr_i  in  GPR_ADDR_W  rs2 address
f_cu_rs2_req_i  in  1  rs2 is read
f_cu_rd_addr_i  in  GPR_ADDR_W  rd address
f_cu_rd_we_i  in  1  instruction writes rd
d_stall_req_i  in  1  decode stall request
e_stall_req_i  in  1  execute busy (MDU multi-cycle)
m_stall_req_i  in  1  memory stage waiting on LSU
e_mispredict_i  in  1  branch/jump resolved in execute, wrong path fetched
m_gpr_wr_en_i  in  1  writeback writes GPR this cycle
m_gpr_wr_addr_i  in  GPR_ADDR_W  writeback address
cu_stall_f_o  out  1  hold fetch
cu_stall_d_o  out  1  hold decode pipeline register
cu_stall_e_o  out  1  hold execute
cu_stall_m_o  out  1  hold memory
cu_kill_f_o  out  1  drop fetch output/in-flight fetch
cu_kill_d_o  out  1  invalidate decode register
cu_kill_e_o  out  1  invalidate execute register
cu_redirect_o  out  1  one-cycle pulse: fetch loads target PC

Behaviour:
- Reset: all scoreboard counters 0, state RUN, D-occupant tracker invalid; all outputs 0.
- Stall/kill outputs are combinational from state, scoreboard registers and inputs. Scoreboard/state update on posedge clk_i.
- hazard = f_valid_i & ((rs1_req & rs1!=0 & cnt[rs1]!=0) | (rs2_req & rs2!=0 & cnt[rs2]!=0) | (rd_we & rd!=0 & cnt[rd]==max)).
  - Evaluated on registered counters. A retire to the same register in the same cycle still stalls, because the GPR read is not write-through.
- Stall priority (highest first):
  - m_stall → all four stalls = 1.
  - e_stall → stall F, D, E.
  - d_stall_req or hazard → stall F only, cu_stall_d_o=0, so decode latches a bubble.
- Issue event = f_valid_i & ~cu_stall_f_o & ~cu_stall_d_o & ~cu_kill_d_o.
  - If rd_we & rd!=0: cnt[rd]+1.
  - Tracker latches {valid, rd, we}. It clears when decode advances without issue; it holds while cu_stall_d_o is asserted.
- Retire: m_gpr_wr_en_i & addr!=0 → cnt[addr]-1.
- Mispredict (e_mispredict_i in RUN, not blocked by m_stall):
  - Same cycle: cu_kill_d_o=1, cu_kill_f_o=1, cu_redirect_o=1; issue suppressed.
  - If the tracker is valid and writes rd → cnt[tracker.rd]-1. This may combine with a retire on the same register (net -2) or on a different register.
  - Next state FLUSH.
- e_mispredict_i while m_stall_req_i=1: no action; the source must hold it until accepted.
- cu_kill_e_o is asserted only on mispredict and only when d_stall_req_i is 1. Otherwise it is 0.
- Simultaneous issue and retire on the same register → counter unchanged.
- A counter never underflows. A decrement at 0 is an assertion failure, and the counter stays 0.
- FSM:
  - RUN: normal operation; mispredict → FLUSH with flush counter = FLUSH_CYCLES-1.
  - FLUSH: cu_kill_f_o=1, cu_stall_d_o=0, no issue. Counter decrements each cycle; at 0 → RUN.
  - FLUSH_CYCLES=1: FLUSH lasts one cycle.
  - e_mispredict_i in FLUSH is ignored.
- Reset asserted mid-operation: immediate return to reset values. Scoreboard contents are lost, because the pipeline is reset too.

Optional Feature:
- Macro RV_PIPELINE_CTRL_PERF_EN.
- When defined, the block adds outputs hazard_stall_cnt_o[31:0], flush_cnt_o[31:0] and mdu_stall_cnt_o[31:0]:
  - hazard_stall_cnt_o counts cycles with hazard-only stall.
  - flush_cnt_o counts accepted mispredicts.
  - mdu_stall_cnt_o counts cycles with e_stall_req_i=1 and m_stall_req_i=0.
  - All three wrap modulo 2^32 and reset to 0.
- When undefined, these ports and registers do not exist.

Test Plan:
- RAW: issue x5 write, next instruction reads rs1=x5 → cu_stall_f_o=1, cu_stall_d_o=0 until the cycle after m_gpr_wr_en_i with addr=5; then issue proceeds.
- x0: rd=0 issued, then rs1=0 read → no stall, all counters stay 0.
- Saturation (CNT_W=2): three issues writing x7 with no retire, fourth instruction writes x7 → stall until one retire of x7, then cnt[7]=3 again.
- Mispredict: D holds a write to x3 (cnt[3]=1), e_mispredict_i=1 → kill_d, kill_f, redirect for 1 cycle; cu_kill_f_o high 2 cycles total; cnt[3]=0.
- Priority: m_stall, e_stall and hazard all 1 → all four stalls 1, no counter change; drop m_stall → stall F, D, E only.
- Mispredict plus retire on the same register x9 (cnt=2) in one cycle → cnt[9]=0; reset mid-FLUSH → state RUN, outputs 0.
